// File: rtl/lopd_normalize_pipe.sv
// lopd_normalize_pipe: two-stage normaliser after the leading-one detector, clamping to denormal on exponent underflow.
// Optional underflow event counter (o_uf_count) enabled by defining LOPD_NORM_UF_CNT_EN.
module lopd_normalize_pipe #(
  parameter int EXP_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [15:0]      i_data,
  input  logic [3:0]       i_pos_one,
  input  logic             i_zero_flag,
  input  logic [EXP_W-1:0] i_exp,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [15:0]      o_data,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_zero,
  output logic             o_underflow
`ifdef LOPD_NORM_UF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_uf_count
`endif
);
  logic             s1_valid_q, s1_valid_d, s1_zero_q, s1_zero_d, s1_uf_q, s1_uf_d;
  logic [15:0]      s1_data_q, s1_data_d;
  logic [3:0]       s1_shift_q, s1_shift_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic             s2_valid_q, s2_valid_d, s2_zero_q, s2_zero_d, s2_uf_q, s2_uf_d;
  logic [15:0]      s2_data_q, s2_data_d;
  logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [3:0]       sa;
  logic             exp_gt, s2_adv, s2_load, in_fire;
  always_comb begin
    sa = 4'd15 - i_pos_one;
    exp_gt = i_exp > EXP_W'(sa);
    s2_adv = ~s2_valid_q | i_ready;
    s2_load = s2_adv & s1_valid_q;
    o_ready = ~s1_valid_q | s2_adv;
    in_fire = i_valid & o_ready;
    s1_valid_d = o_ready ? i_valid : s1_valid_q;
    s1_data_d = in_fire ? i_data : s1_data_q;
    s1_zero_d = in_fire ? i_zero_flag : s1_zero_q;
    s1_uf_d = in_fire ? (~i_zero_flag & ~exp_gt) : s1_uf_q;
    s1_exp_d = !in_fire ? s1_exp_q : (i_zero_flag | ~exp_gt) ? '0 : i_exp - EXP_W'(sa);
    // On underflow shift only as far as the exponent allows, landing at exponent 0.
    s1_shift_d = !in_fire ? s1_shift_q : i_zero_flag ? 4'd0 : exp_gt ? sa :
                 (i_exp == '0) ? 4'd0 : 4'(i_exp - EXP_W'(1));
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_data_d = !s2_load ? s2_data_q : s1_zero_q ? 16'd0 : s1_data_q << s1_shift_q;
    s2_exp_d = s2_load ? s1_exp_q : s2_exp_q;
    s2_zero_d = s2_load ? s1_zero_q : s2_zero_q;
    s2_uf_d = s2_load ? s1_uf_q : s2_uf_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_shift_q <= '0;
      s1_exp_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_uf_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_exp_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_uf_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_shift_q <= s1_shift_d;
      s1_exp_q   <= s1_exp_d;
      s1_zero_q  <= s1_zero_d;
      s1_uf_q    <= s1_uf_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_exp_q   <= s2_exp_d;
      s2_zero_q  <= s2_zero_d;
      s2_uf_q    <= s2_uf_d;
    end
  end
  assign o_valid     = s2_valid_q;
  assign o_data      = s2_data_q;
  assign o_exp       = s2_exp_q;
  assign o_zero      = s2_zero_q;
  assign o_underflow = s2_uf_q;
`ifdef LOPD_NORM_UF_CNT_EN
  logic [CNT_W-1:0] uf_cnt_q, uf_cnt_d;
  always_comb begin
    uf_cnt_d = (o_valid & i_ready & o_underflow & (uf_cnt_q != '1)) ? uf_cnt_q + CNT_W'(1) : uf_cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) uf_cnt_q <= '0;
    else uf_cnt_q <= uf_cnt_d;
  end
  assign o_uf_count = uf_cnt_q;
`endif
endmodule

// File: tb/tb_lopd_normalize_pipe.sv
// tb_lopd_normalize_pipe: directed self-checking bench for lopd_normalize_pipe.
module tb_lopd_normalize_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_data = '0;
  logic [3:0]  i_pos_one = '0;
  logic        i_zero_flag = 1'b0;
  logic [7:0]  i_exp = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [15:0] o_data;
  logic [7:0]  o_exp;
  logic        o_zero;
  logic        o_underflow;
`ifdef LOPD_NORM_UF_CNT_EN
  logic [1:0]  o_uf_count;
`endif
  int checks = 0;
  int errors = 0;

  lopd_normalize_pipe #(.EXP_W(8), .CNT_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_pos_one(i_pos_one), .i_zero_flag(i_zero_flag), .i_exp(i_exp),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_exp(o_exp),
    .o_zero(o_zero), .o_underflow(o_underflow)
`ifdef LOPD_NORM_UF_CNT_EN
    , .o_uf_count(o_uf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] p, input logic z, input logic [7:0] e);
    i_valid = v; i_data = d; i_pos_one = p; i_zero_flag = z; i_exp = e;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({o_valid, o_data, o_exp, o_zero, o_underflow} !== 27'd0) begin
      errors++; $display("FAIL reset_outputs: got v=%b d=%h e=%0d z=%b u=%b want all 0", o_valid, o_data, o_exp, o_zero, o_underflow);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got o_ready=%b o_valid=%b want 1 0", o_ready, o_valid);
    end
  endtask

  // vectors: data, pos, zero, exp -> data, exp, zero, uf
  task automatic test_normalize;
    logic [15:0] vd [7] = '{16'h0001, 16'h00F0, 16'h0000, 16'h0010, 16'h0010, 16'h0100, 16'h8001};
    logic [3:0]  vp [7] = '{4'd0, 4'd7, 4'd3, 4'd4, 4'd4, 4'd8, 4'd15};
    logic        vz [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0]  ve [7] = '{8'd20, 8'd4, 8'd100, 8'd11, 8'd12, 8'd0, 8'd7};
    logic [15:0] xd [7] = '{16'h8000, 16'h0780, 16'h0000, 16'h4000, 16'h8000, 16'h0100, 16'h8001};
    logic [7:0]  xe [7] = '{8'd5, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd7};
    logic        xz [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        xu [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); drive(1'b1, vd[i], vp[i], vz[i], ve[i]);
      @(negedge clk); drive(1'b0, 16'h0, 4'd0, 1'b0, 8'd0);
      checks++;
      if (o_valid !== 1'b0) begin
        errors++; $display("FAIL latency_vec%0d: o_valid=%b after 1 cycle want 0", i, o_valid);
      end
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_data !== xd[i] || o_exp !== xe[i] || o_zero !== xz[i] || o_underflow !== xu[i]) begin
        errors++;
        $display("FAIL norm_vec%0d: got v=%b d=%h e=%0d z=%b u=%b want v=1 d=%h e=%0d z=%b u=%b",
                 i, o_valid, o_data, o_exp, o_zero, o_underflow, xd[i], xe[i], xz[i], xu[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] e [4] = '{8'd40, 8'd41, 8'd42, 8'd43};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (o_valid !== 1'b1 || o_exp !== e[i-2] - 8'd3 || o_data !== 16'h8000) begin
          errors++; $display("FAIL b2b_beat%0d: got v=%b e=%0d d=%h want v=1 e=%0d d=8000", i-2, o_valid, o_exp, o_data, e[i-2] - 8'd3);
        end
      end
      if (i < 4) drive(1'b1, 16'h1000, 4'd12, 1'b0, e[i]);
      else drive(1'b0, 16'h0, 4'd0, 1'b0, 8'd0);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: o_valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_backpressure;
    i_ready = 1'b0;
    @(negedge clk); drive(1'b1, 16'h8001, 4'd15, 1'b0, 8'd30);
    @(negedge clk); drive(1'b1, 16'h8002, 4'd15, 1'b0, 8'd31);
    @(negedge clk); drive(1'b1, 16'h8003, 4'd15, 1'b0, 8'd32);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_exp !== 8'd30 || o_data !== 16'h8001) begin
        errors++; $display("FAIL bp_hold%0d: got rdy=%b v=%b e=%0d d=%h want rdy=0 v=1 e=30 d=8001", k, o_ready, o_valid, o_exp, o_data);
      end
      @(negedge clk);
    end
    i_ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_comb: o_ready=%b want 1", o_ready);
    end
    @(negedge clk); drive(1'b0, 16'h0, 4'd0, 1'b0, 8'd0);
    checks++;
    if (o_valid !== 1'b1 || o_exp !== 8'd31 || o_data !== 16'h8002) begin
      errors++; $display("FAIL bp_beat1: got v=%b e=%0d d=%h want v=1 e=31 d=8002", o_valid, o_exp, o_data);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_exp !== 8'd32 || o_data !== 16'h8003) begin
      errors++; $display("FAIL bp_beat2: got v=%b e=%0d d=%h want v=1 e=32 d=8003", o_valid, o_exp, o_data);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: o_valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_reset_midflight;
    i_ready = 1'b0;
    @(negedge clk); drive(1'b1, 16'h0001, 4'd0, 1'b0, 8'd50);
    @(negedge clk); drive(1'b1, 16'h0002, 4'd1, 1'b0, 8'd51);
    @(negedge clk); drive(1'b0, 16'h0, 4'd0, 1'b0, 8'd0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_data, o_exp, o_zero, o_underflow} !== 27'd0) begin
      errors++; $display("FAIL async_reset: got v=%b d=%h e=%0d z=%b u=%b want all 0", o_valid, o_data, o_exp, o_zero, o_underflow);
    end
    i_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); drive(1'b1, 16'h0004, 4'd2, 1'b0, 8'd60);
    @(negedge clk); drive(1'b0, 16'h0, 4'd0, 1'b0, 8'd0);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_latency: o_valid=%b after 1 cycle want 0", o_valid);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h8000 || o_exp !== 8'd47) begin
      errors++; $display("FAIL post_reset_beat: got v=%b d=%h e=%0d want v=1 d=8000 e=47", o_valid, o_data, o_exp);
    end
    @(negedge clk);
  endtask

`ifdef LOPD_NORM_UF_CNT_EN
  task automatic test_uf_count;
    logic [1:0] want [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 5) drive(1'b1, 16'h00F0, 4'd7, 1'b0, 8'd4);
      else drive(1'b1, 16'h0001, 4'd0, 1'b0, 8'd20);
      @(negedge clk); drive(1'b0, 16'h0, 4'd0, 1'b0, 8'd0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (o_uf_count !== want[i]) begin
        errors++; $display("FAIL uf_count%0d: got %0d want %0d", i, o_uf_count, want[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_normalize;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
`ifdef LOPD_NORM_UF_CNT_EN
    test_uf_count;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lopd_normalize_pipe.md
Name: lopd_normalize_pipe

Overview:
Normalisation stage that sits directly downstream of the 16-bit leading-one position detector in the ADD_SUB datapath.
- Consumes the raw 16-bit mantissa sum, the detector's leading-one position and zero flag, and the biased exponent.
- Left-shifts the mantissa so that the leading one lands in bit 15, and adjusts the exponent by the same amount.
- When the exponent cannot absorb the shift, clamps to a denormal result.
- Two-stage valid/ready pipeline with full backpressure support.

Parameters:
EXP_W, 8, width of biased exponent in/out
CNT_W, 16, width of underflow event counter (used only with optional feature)

Ports:
i_clk  input  1  clock; the block's only clock
i_rst_n  input  1  asynchronous, active-low reset
i_valid  input  1  upstream beat valid
o_ready  output  1  block can accept a beat this cycle
i_data  input  16  unnormalised mantissa sum
i_pos_one  input  4  leading-one index (0..15), from the detector
i_zero_flag  input  1  i_data is all zero, from the detector
i_exp  input  EXP_W  biased exponent before normalisation
o_valid  output  1  result beat valid
i_ready  input  1  downstream accepts result
o_data  output  16  normalised mantissa
o_exp  output  EXP_W  adjusted exponent
o_zero  output  1  result is exact zero
o_underflow  output  1  result was clamped to denormal

Behaviour:
- Clocking/reset: one clock (i_clk). Reset is asynchronous, active-low (i_rst_n).
- Reset values: all pipeline valids = 0; o_valid = 0; o_data, o_exp, o_zero and o_underflow = 0; o_ready = 1 once reset deasserts.
- Transfer rules:
  - An input transfer occurs on a rising edge with i_valid & o_ready.
  - An output transfer occurs with o_valid & i_ready.
  - Once o_valid is high, the block holds o_data, o_exp, o_zero and o_underflow stable until the output transfer occurs.
- Stage 1 (S1): registers the beat and computes:
  - sa = 15 - i_pos_one (4-bit, 0..15).
  - Exponent decision, evaluated in this order:
    - If i_zero_flag: shift = 0, exp_out = 0, zero = 1, uf = 0.
    - Else if i_exp > sa (unsigned, EXP_W-bit compare with zero-extended sa): shift = sa, exp_out = i_exp - sa, uf = 0.
    - Else (i_exp <= sa): shift = (i_exp == 0) ? 0 : i_exp - 1 (fits in 4 bits), exp_out = 0, uf = 1.
- Stage 2 (S2): barrel left-shifts the S1 mantissa by shift, zero-filling from the LSB, and registers the outputs.
  - Data is zeroed when zero = 1.
- Latency: 2 cycles from input transfer to o_valid with i_ready held high. Throughput: 1 beat per cycle.
- Backpressure:
  - S2 advances when S2 is empty or being consumed.
  - S1 advances into S2 under the same condition.
  - o_ready = ~s1_valid | s2_advance.
  - No combinational path from i_valid to o_valid. The only combinational path is i_ready -> o_ready.
  - Holding capacity: 2 beats. Order is preserved; no beat is dropped or duplicated.
- Simultaneous events: input and output transfers in the same cycle are legal at full occupancy; the pipeline shifts by one.
- Detector inputs: i_pos_one is trusted when i_zero_flag = 0. i_pos_one is a don't-care when i_zero_flag = 1.
- Reset mid-operation: in-flight beats are discarded and all outputs return to their reset values immediately (asynchronously).

Optional Feature:
Macro: LOPD_NORM_UF_CNT_EN
- Defined:
  - Adds output o_uf_count [CNT_W-1:0].
  - Increments by 1 on each output transfer with o_underflow = 1.
  - Saturates at all-ones; resets to 0.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- i_data=16'h0001, i_pos_one=0, i_exp=20, i_ready=1 -> 2 cycles later: o_data=16'h8000, o_exp=5, o_underflow=0, o_zero=0.
- i_data=16'h00F0, i_pos_one=7, i_exp=4 -> o_data=16'h0780, o_exp=0, o_underflow=1.
- i_zero_flag=1, i_data=0, i_exp=100 -> o_data=0, o_exp=0, o_zero=1, o_underflow=0.
- Backpressure: i_ready=0 with 3 consecutive i_valid beats (exp 30/31/32) -> o_ready drops after 2 accepted and o_valid output stays stable; then i_ready=1 -> beats emerge in order, third accepted, none lost.
- Reset: assert i_rst_n=0 with 2 beats in flight -> o_valid=0 and outputs zero immediately; after release, the first beat returns with 2-cycle latency.
- With LOPD_NORM_UF_CNT_EN, CNT_W=2: 5 underflow beats -> o_uf_count = 1, 2, 3, 3, 3; non-underflow beats leave it unchanged.
